// File: rtl/canvas_write_arbiter.sv
// Arbitrates pixel writes from a freehand tool and a full-layer clear sweep
// onto four canvases sharing one registered write port.
module canvas_write_arbiter #(
    parameter  int WIDTH       = 640,
    parameter  int HEIGHT      = 480,
    parameter  int COLOR_WIDTH = 4,
    parameter  int CLEAR_COLOR = 0,
    localparam int XW          = $clog2(WIDTH),
    localparam int YW          = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tool_valid,
    input  logic [XW-1:0]          tool_x,
    input  logic [YW-1:0]          tool_y,
    input  logic [COLOR_WIDTH-1:0] tool_color,
    input  logic [2:0]             current_layer,
    input  logic [3:0]             layer_visible,
    input  logic                   clear_start,
    input  logic [2:0]             clear_layer,
    output logic                   tool_ready,
    output logic [3:0]             wr_enable,
    output logic [XW-1:0]          wr_x,
    output logic [YW-1:0]          wr_y,
    output logic [COLOR_WIDTH-1:0] wr_color,
    output logic                   clear_busy,
    output logic                   clear_done
);

    localparam logic [XW-1:0]          X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0]          Y_MAX = YW'(HEIGHT - 1);
    localparam logic [COLOR_WIDTH-1:0] CLR   = COLOR_WIDTH'(CLEAR_COLOR);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          cx_q, cx_d;
    logic [YW-1:0]          cy_q, cy_d;
    logic [2:0]             layer_q, layer_d;
    logic [3:0]             wr_en_q, wr_en_d;
    logic [XW-1:0]          wr_x_q, wr_x_d;
    logic [YW-1:0]          wr_y_q, wr_y_d;
    logic [COLOR_WIDTH-1:0] wr_color_q, wr_color_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Layers 1..4 map to strobe bits 0..3; anything else selects no canvas.
    function automatic logic [3:0] layer_onehot(input logic [2:0] layer);
        case (layer)
            3'd1:    layer_onehot = 4'b0001;
            3'd2:    layer_onehot = 4'b0010;
            3'd3:    layer_onehot = 4'b0100;
            3'd4:    layer_onehot = 4'b1000;
            default: layer_onehot = 4'b0000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        layer_d    = layer_q;
        wr_en_d    = 4'b0000;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start && (layer_onehot(clear_layer) != 4'b0000)) begin
                    state_d    = CLEAR;
                    layer_d    = clear_layer;
                    cx_d       = '0;
                    cy_d       = '0;
                    wr_en_d    = layer_onehot(clear_layer);
                    wr_x_d     = '0;
                    wr_y_d     = '0;
                    wr_color_d = CLR;
                    busy_d     = 1'b1;
                end else if (tool_valid) begin
                    // Address/data only move when a canvas is actually strobed.
                    wr_en_d = layer_onehot(current_layer) & layer_visible;
                    if (wr_en_d != 4'b0000) begin
                        wr_x_d     = tool_x;
                        wr_y_d     = tool_y;
                        wr_color_d = tool_color;
                    end
                end
            end
            CLEAR: begin
                // cx_q/cy_q track the pixel currently presented on wr_*.
                if ((cx_q == X_MAX) && (cy_q == Y_MAX)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == X_MAX) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    wr_en_d    = layer_onehot(layer_q);
                    wr_x_d     = cx_d;
                    wr_y_d     = cy_d;
                    wr_color_d = CLR;
                    busy_d     = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            layer_q    <= '0;
            wr_en_q    <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_color_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            layer_q    <= layer_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tool_ready = (state_q == IDLE);
    assign wr_enable  = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_color   = wr_color_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Directed bench for canvas_write_arbiter on an 8x8 canvas with a nonzero clear color.
module tb_canvas_write_arbiter;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 4;
    localparam logic [CW-1:0] CLR = 4'd5;

    logic          clk = 1'b0;
    logic          reset;
    logic          tool_valid;
    logic [2:0]    tool_x;
    logic [2:0]    tool_y;
    logic [CW-1:0] tool_color;
    logic [2:0]    current_layer;
    logic [3:0]    layer_visible;
    logic          clear_start;
    logic [2:0]    clear_layer;
    logic          tool_ready;
    logic [3:0]    wr_enable;
    logic [2:0]    wr_x;
    logic [2:0]    wr_y;
    logic [CW-1:0] wr_color;
    logic          clear_busy;
    logic          clear_done;

    int n_cmp  = 0;
    int n_fail = 0;

    canvas_write_arbiter #(
        .WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW), .CLEAR_COLOR(5)
    ) dut (
        .clk(clk), .reset(reset),
        .tool_valid(tool_valid), .tool_x(tool_x), .tool_y(tool_y), .tool_color(tool_color),
        .current_layer(current_layer), .layer_visible(layer_visible),
        .clear_start(clear_start), .clear_layer(clear_layer),
        .tool_ready(tool_ready), .wr_enable(wr_enable), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color, clear_busy, clear_done} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%b x=%0d y=%0d c=%0d busy=%b done=%b want all 0",
                     wr_enable, wr_x, wr_y, wr_color, clear_busy, clear_done);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (tool_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b want=1", tool_ready);
        end
    endtask

    task automatic test_tool_write();
        current_layer = 3'd2; layer_visible = 4'b0010;
        tool_x = 3'd3; tool_y = 3'd5; tool_color = 4'd6; tool_valid = 1'b1;
        tick();
        tool_valid = 1'b0;
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color} !== {4'b0010, 3'd3, 3'd5, 4'd6}) begin
            n_fail++;
            $display("FAIL tool_write got en=%b x=%0d y=%0d c=%0d want en=0010 x=3 y=5 c=6",
                     wr_enable, wr_x, wr_y, wr_color);
        end
        tick();
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color} !== {4'b0000, 3'd3, 3'd5, 4'd6}) begin
            n_fail++;
            $display("FAIL tool_hold got en=%b x=%0d y=%0d c=%0d want en=0000 x=3 y=5 c=6",
                     wr_enable, wr_x, wr_y, wr_color);
        end
    endtask

    task automatic test_invisible();
        // Each row: layer, visible mask; none of these may strobe a canvas.
        logic [2:0] lay [3] = '{3'd2, 3'd0, 3'd5};
        logic [3:0] vis [3] = '{4'b0000, 4'b1111, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            current_layer = lay[k]; layer_visible = vis[k];
            tool_x = 3'd1; tool_y = 3'd2; tool_color = 4'd7; tool_valid = 1'b1;
            tick();
            tool_valid = 1'b0;
            n_cmp++;
            if ({wr_enable, wr_x, wr_y, wr_color} !== {4'b0000, 3'd3, 3'd5, 4'd6}) begin
                n_fail++;
                $display("FAIL invisible_%0d got en=%b x=%0d y=%0d c=%0d want en=0000 x=3 y=5 c=6",
                         k, wr_enable, wr_x, wr_y, wr_color);
            end
        end
    endtask

    task automatic test_back_to_back();
        current_layer = 3'd1; layer_visible = 4'b0001;
        tool_x = 3'd1; tool_y = 3'd1; tool_color = 4'd1; tool_valid = 1'b1;
        tick();
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color} !== {4'b0001, 3'd1, 3'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL b2b_first got en=%b x=%0d y=%0d c=%0d want en=0001 x=1 y=1 c=1",
                     wr_enable, wr_x, wr_y, wr_color);
        end
        current_layer = 3'd4; layer_visible = 4'b1000;
        tool_x = 3'd7; tool_y = 3'd6; tool_color = 4'd15;
        tick();
        tool_valid = 1'b0;
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color} !== {4'b1000, 3'd7, 3'd6, 4'd15}) begin
            n_fail++;
            $display("FAIL b2b_second got en=%b x=%0d y=%0d c=%0d want en=1000 x=7 y=6 c=15",
                     wr_enable, wr_x, wr_y, wr_color);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [2:0] ex, ey;
        clear_layer = 3'd3; clear_start = 1'b1;
        current_layer = 3'd2; layer_visible = 4'b1111;
        tool_x = 3'd2; tool_y = 3'd2; tool_color = 4'd9;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            ex = i[2:0];
            ey = i[5:3];
            n_cmp++;
            if ({clear_busy, clear_done, tool_ready, wr_enable, wr_x, wr_y, wr_color} !==
                {1'b1, 1'b0, 1'b0, 4'b0100, ex, ey, CLR}) begin
                n_fail++;
                $display("FAIL sweep_px%0d got busy=%b done=%b rdy=%b en=%b x=%0d y=%0d c=%0d want busy=1 done=0 rdy=0 en=0100 x=%0d y=%0d c=%0d",
                         i, clear_busy, clear_done, tool_ready, wr_enable, wr_x, wr_y, wr_color,
                         ex, ey, CLR);
            end
            tool_valid  = (i >= 10 && i <= 12);
            clear_start = (i == 20);
            clear_layer = (i == 20) ? 3'd1 : 3'd3;
            tick();
        end
        tool_valid = 1'b0; clear_start = 1'b0;
        n_cmp++;
        if ({clear_done, clear_busy, tool_ready, wr_enable, wr_x, wr_y} !==
            {1'b1, 1'b0, 1'b0, 4'b0000, 3'd7, 3'd7}) begin
            n_fail++;
            $display("FAIL sweep_done got done=%b busy=%b rdy=%b en=%b x=%0d y=%0d want done=1 busy=0 rdy=0 en=0000 x=7 y=7",
                     clear_done, clear_busy, tool_ready, wr_enable, wr_x, wr_y);
        end
        tick();
        n_cmp++;
        if ({clear_done, clear_busy, tool_ready, wr_enable} !== {1'b0, 1'b0, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL sweep_after got done=%b busy=%b rdy=%b en=%b want done=0 busy=0 rdy=1 en=0000",
                     clear_done, clear_busy, tool_ready, wr_enable);
        end
    endtask

    task automatic test_simultaneous_and_abort();
        int done_seen, busy_seen;
        current_layer = 3'd2; layer_visible = 4'b0010;
        tool_x = 3'd6; tool_y = 3'd6; tool_color = 4'd9; tool_valid = 1'b1;
        clear_layer = 3'd1; clear_start = 1'b1;
        tick();
        tool_valid = 1'b0; clear_start = 1'b0;
        n_cmp++;
        if ({clear_busy, wr_enable, wr_x, wr_y, wr_color} !== {1'b1, 4'b0001, 3'd0, 3'd0, CLR}) begin
            n_fail++;
            $display("FAIL clear_wins got busy=%b en=%b x=%0d y=%0d c=%0d want busy=1 en=0001 x=0 y=0 c=%0d",
                     clear_busy, wr_enable, wr_x, wr_y, wr_color, CLR);
        end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ({clear_busy, wr_enable, wr_x, wr_y} !== {1'b1, 4'b0001, 3'd4, 3'd2}) begin
            n_fail++;
            $display("FAIL sweep_px20 got busy=%b en=%b x=%0d y=%0d want busy=1 en=0001 x=4 y=2",
                     clear_busy, wr_enable, wr_x, wr_y);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({wr_enable, wr_x, wr_y, wr_color, clear_busy, clear_done, tool_ready} !== {16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_reset got en=%b x=%0d y=%0d c=%0d busy=%b done=%b rdy=%b want all 0 rdy=1",
                     wr_enable, wr_x, wr_y, wr_color, clear_busy, clear_done, tool_ready);
        end
        reset = 1'b0;
        done_seen = 0; busy_seen = 0;
        for (int i = 0; i < W * H + 4; i++) begin
            tick();
            if (clear_done === 1'b1) done_seen++;
            if (clear_busy === 1'b1) busy_seen++;
        end
        n_cmp++;
        if (done_seen != 0 || busy_seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done got done_cycles=%0d busy_cycles=%0d want 0 and 0",
                     done_seen, busy_seen);
        end
    endtask

    task automatic test_bad_layer();
        logic [2:0] bad [3] = '{3'd0, 3'd5, 3'd7};
        for (int k = 0; k < 3; k++) begin
            clear_layer = bad[k]; clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
            n_cmp++;
            if ({clear_busy, wr_enable, tool_ready} !== {1'b0, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL bad_layer_%0d got busy=%b en=%b rdy=%b want busy=0 en=0000 rdy=1",
                         bad[k], clear_busy, wr_enable, tool_ready);
            end
        end
    endtask

    initial begin
        reset = 1'b1; tool_valid = 1'b0; tool_x = '0; tool_y = '0; tool_color = '0;
        current_layer = '0; layer_visible = '0; clear_start = 1'b0; clear_layer = '0;
        test_reset();
        test_tool_write();
        test_invisible();
        test_back_to_back();
        test_sweep();
        test_simultaneous_and_abort();
        test_bad_layer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/canvas_write_arbiter.md
CANVAS_WRITE_ARBITER -- requirements
Module: canvas_write_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 640, canvas width in pixels; HEIGHT, default 480, canvas height in pixels; CLEAR_COLOR, default 0, color index written by a clear sweep.
REQ-002 Color ports SHALL use the common COLOR_WIDTH; coordinate widths SHALL be XW=$clog2(WIDTH) and YW=$clog2(HEIGHT).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tool_valid  in  1  freehand tool requests a pixel write this cycle.
REQ-006 tool_x / tool_y / tool_color  in  XW / YW / COLOR_WIDTH  tool write coordinate and color.
REQ-007 current_layer  in  3  layer selected for tool writes; valid values 1..4.
REQ-008 layer_visible  in  4  bit n-1 high = layer n visible.
REQ-009 clear_start  in  1  request to clear one layer.
REQ-010 clear_layer  in  3  layer to clear; valid values 1..4.
REQ-011 tool_ready  out  1  high = a tool_valid this cycle is accepted.
REQ-012 wr_enable  out  4  one-hot canvas write strobe; bit n-1 drives canvas n.
REQ-013 wr_x / wr_y / wr_color  out  XW / YW / COLOR_WIDTH  shared write address and data for all canvases.
REQ-014 clear_busy  out  1  clear sweep in progress.
REQ-015 clear_done  out  1  one-cycle pulse at the end of a sweep.

Function
REQ-016 The FSM SHALL have three states: IDLE, CLEAR, DONE.
REQ-017 IDLE->CLEAR SHALL occur when clear_start=1 and clear_layer is 1..4; clear_layer SHALL be latched at that edge.
REQ-018 In IDLE, clear_start with clear_layer 0 or 5..7 SHALL be ignored.
REQ-019 In CLEAR or DONE, clear_start SHALL be ignored.
REQ-020 In CLEAR, each cycle SHALL emit one write of CLEAR_COLOR to the latched layer, regardless of layer_visible.
REQ-021 Sweep order: x increments 0..WIDTH-1; at x=WIDTH-1, x wraps to 0 and y increments.
REQ-022 Pixel (0,0) SHALL appear on wr_* in the first cycle clear_busy=1.
REQ-023 Pixel (WIDTH-1,HEIGHT-1) SHALL appear exactly WIDTH*HEIGHT-1 cycles after pixel (0,0).
REQ-024 After the last pixel write, CLEAR->DONE; in DONE, clear_done=1, clear_busy=0, wr_enable=0 for exactly one cycle; then DONE->IDLE.
REQ-025 clear_busy SHALL be high exactly WIDTH*HEIGHT cycles per sweep.
REQ-026 Coordinate counters SHALL never exceed WIDTH-1 / HEIGHT-1, including non-power-of-two sizes.
REQ-027 tool_ready SHALL be 1 in IDLE and 0 in CLEAR and DONE.
REQ-028 A tool_valid while tool_ready=0 SHALL be dropped and never replayed.
REQ-029 An accepted tool write (tool_valid=1, tool_ready=1) in cycle N SHALL appear on wr_x/wr_y/wr_color in cycle N+1.
REQ-030 That write's wr_enable SHALL be one-hot on bit current_layer-1 only if current_layer is 1..4 and that layer's layer_visible bit is 1; otherwise wr_enable=0.
REQ-031 If clear_start and tool_valid are both high in IDLE, the clear SHALL win: the cycle-N+1 output is clear pixel (0,0) and the tool write is dropped.
REQ-032 All outputs except tool_ready SHALL be registered.
REQ-033 wr_enable SHALL never have more than one bit set.
REQ-034 When wr_enable=0, wr_x, wr_y and wr_color SHALL hold their previous values.

Reset
REQ-035 While reset=1 at a clock edge: state=IDLE, counters=0, wr_enable=0, wr_x=0, wr_y=0, wr_color=0, clear_busy=0, clear_done=0.
REQ-036 Reset during CLEAR or DONE SHALL abort the sweep with no clear_done pulse; canvases keep any partial clear.
REQ-037 tool_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=HEIGHT=8)
REQ-038 Tool write: current_layer=2, layer_visible=4'b0010, tool_valid pulse at (3,5), color 6 -> next cycle wr_enable=4'b0010, wr_x=3, wr_y=5, wr_color=6.
REQ-039 Invisible or invalid layer: layer_visible=4'b0000 or current_layer=0, tool_valid pulse -> wr_enable stays 0.
REQ-040 Full sweep: clear_start with clear_layer=3 -> wr_enable=4'b0100 for 64 consecutive cycles, covering (0,0),(1,0)..(7,7) in order.
REQ-041 Sweep end: after REQ-040 -> clear_done high for one cycle, clear_busy low, tool_ready back to 1 the following cycle.
REQ-042 Simultaneous and blocked requests: clear_start with tool_valid in the same IDLE cycle -> clear wins, tool write absent; tool_valid pulses mid-sweep -> no tool write ever appears.
REQ-043 Reset and bad layer: reset at sweep cycle 20 -> next cycle all outputs 0, state IDLE, no clear_done; clear_start with clear_layer=0 or 5 -> clear_busy stays 0.
